// File: rtl/alarma_pkg.sv
// Shared definitions for the plant alarm controller and the blocks around it.
package alarma_pkg;

  localparam int ESTADO_W = 2;

  // Thresholds shared with the display block.
  localparam int UMBRAL_SECO_DEF   = 80;
  localparam int UMBRAL_HUMEDO_DEF = 100;

  typedef enum logic [ESTADO_W-1:0] {
    REPOSO   = 2'd0,
    CONTEO   = 2'd1,
    ALARMA   = 2'd2,
    SILENCIO = 2'd3
  } estado_t;

endpackage

// File: rtl/alarma_ctrl_antirrebote.sv
// Button debouncer: the level follows the synchronized input only after it has
// disagreed for DEB_CYC consecutive clocks; a rising level change emits one press.
module antirrebote #(
  parameter int unsigned DEB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic boton_sync,
  output logic nivel,
  output logic pulsacion
);

  localparam logic [19:0] DEB_LAST = 20'(DEB_CYC - 1);

  logic [19:0] cnt;

  // Count consecutive disagreeing samples; accept the new level on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      nivel     <= 1'b0;
      pulsacion <= 1'b0;
      cnt       <= '0;
    end else begin
      pulsacion <= 1'b0;
      if (boton_sync != nivel) begin
        if (cnt == DEB_LAST) begin
          nivel     <= boton_sync;
          pulsacion <= boton_sync;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 20'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/alarma_ctrl.sv
// Plant alarm controller: filters moisture samples with hysteresis and a
// consecutive-dry count, drives the melody generator enable/restart and
// handles a timed snooze from a debounced push-button.
//
// state    | meaning
// REPOSO   | soil fine, waiting for a dry sample
// CONTEO   | counting consecutive dry samples
// ALARMA   | generator enabled, melody restarted every T_ALARMA clocks
// SILENCIO | snoozed for T_SILENCIO clocks
module alarma_ctrl
  import alarma_pkg::*;
#(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned UMBRAL_SECO   = UMBRAL_SECO_DEF,
  parameter int unsigned UMBRAL_HUMEDO = UMBRAL_HUMEDO_DEF,
  parameter int unsigned N_CONSEC      = 4,
  parameter int unsigned T_ALARMA      = 1_090_000_000,
  parameter int unsigned T_SILENCIO    = 500_000_000,
  parameter int unsigned DEB_CYC       = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                muestra_valid,
  input  logic [DATA_W-1:0]   muestra,
  input  logic                boton_silencio,
  output logic                alarma_en,
  output logic                alarma_reinicio,
  output logic                seco,
  output logic [ESTADO_W-1:0] estado
);

  localparam int unsigned CNT_W = $clog2(N_CONSEC + 1);

  localparam logic [DATA_W-1:0] LIM_SECO   = DATA_W'(UMBRAL_SECO);
  localparam logic [DATA_W-1:0] LIM_HUMEDO = DATA_W'(UMBRAL_HUMEDO);
  localparam logic [CNT_W-1:0]  N_CNT      = CNT_W'(N_CONSEC);
  localparam logic [31:0]       T_A_LAST   = 32'(T_ALARMA - 1);
  localparam logic [31:0]       T_S_LAST   = 32'(T_SILENCIO - 1);

  logic       sync_1, sync_2;
  logic       pulsacion;
  logic       nivel_unused;

  estado_t    estado_r, estado_sig;
  logic [CNT_W-1:0] cnt_r, cnt_sig;
  logic [31:0] tmr_r, tmr_sig;
  logic       reinicio_sig;
  logic       es_seco, es_humedo;

  assign es_seco   = muestra_valid && (muestra < LIM_SECO);
  assign es_humedo = muestra_valid && (muestra >= LIM_HUMEDO);

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= boton_silencio;
      sync_2 <= sync_1;
    end
  end

  antirrebote #(
    .DEB_CYC(DEB_CYC)
  ) u_antirrebote (
    .clk       (clk),
    .rst       (rst),
    .boton_sync(sync_2),
    .nivel     (nivel_unused),
    .pulsacion (pulsacion)
  );

  // Hysteresis flag: set on dry, cleared on wet, held in between.
  always_ff @(posedge clk) begin
    if (rst) begin
      seco <= 1'b0;
    end else if (es_seco) begin
      seco <= 1'b1;
    end else if (es_humedo) begin
      seco <= 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_r        <= REPOSO;
      cnt_r           <= '0;
      tmr_r           <= '0;
      alarma_en       <= 1'b0;
      alarma_reinicio <= 1'b0;
    end else begin
      estado_r        <= estado_sig;
      cnt_r           <= cnt_sig;
      tmr_r           <= tmr_sig;
      alarma_en       <= (estado_sig == ALARMA);
      alarma_reinicio <= reinicio_sig;
    end
  end

  // Next state; priority is wet sample, then press, then timer expiry.
  always_comb begin
    estado_sig   = estado_r;
    cnt_sig      = cnt_r;
    tmr_sig      = tmr_r;
    reinicio_sig = 1'b0;
    case (estado_r)
      REPOSO: begin
        cnt_sig = '0;
        tmr_sig = '0;
        if (es_seco) begin
          cnt_sig = CNT_W'(1);
          if (N_CONSEC == 1) begin
            estado_sig   = ALARMA;
            reinicio_sig = 1'b1;
          end else begin
            estado_sig = CONTEO;
          end
        end
      end
      CONTEO: begin
        if (es_seco) begin
          cnt_sig = cnt_r + CNT_W'(1);
          if ((cnt_r + CNT_W'(1)) == N_CNT) begin
            estado_sig   = ALARMA;
            tmr_sig      = '0;
            reinicio_sig = 1'b1;
          end
        end else if (muestra_valid) begin
          estado_sig = REPOSO;
          cnt_sig    = '0;
          tmr_sig    = '0;
        end
      end
      ALARMA: begin
        if (es_humedo) begin
          estado_sig = REPOSO;
          cnt_sig    = '0;
          tmr_sig    = '0;
        end else if (pulsacion) begin
          estado_sig = SILENCIO;
          tmr_sig    = '0;
        end else if (tmr_r == T_A_LAST) begin
          tmr_sig      = '0;
          reinicio_sig = 1'b1;
        end else begin
          tmr_sig = tmr_r + 32'd1;
        end
      end
      SILENCIO: begin
        if (es_humedo) begin
          estado_sig = REPOSO;
          cnt_sig    = '0;
          tmr_sig    = '0;
        end else if (tmr_r == T_S_LAST) begin
          tmr_sig = '0;
          if (seco) begin
            estado_sig   = ALARMA;
            reinicio_sig = 1'b1;
          end else begin
            estado_sig = REPOSO;
            cnt_sig    = '0;
          end
        end else begin
          tmr_sig = tmr_r + 32'd1;
        end
      end
      default: begin
        estado_sig = REPOSO;
        cnt_sig    = '0;
        tmr_sig    = '0;
      end
    endcase
  end

  assign estado = estado_r;

endmodule

// File: tb/tb_alarma_ctrl.sv
// Self-checking bench for alarma_ctrl: directed scenarios followed by random
// samples and button activity, all compared cycle by cycle with a reference model.
module tb_alarma_ctrl;

  localparam int NC = 3;
  localparam int TA = 100;
  localparam int TS = 50;
  localparam int DB = 4;

  localparam int M_REPOSO   = 0;
  localparam int M_CONTEO   = 1;
  localparam int M_ALARMA   = 2;
  localparam int M_SILENCIO = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       muestra_valid;
  logic [7:0] muestra;
  logic       boton_silencio;
  logic       alarma_en;
  logic       alarma_reinicio;
  logic       seco;
  logic [1:0] estado;

  int checks   = 0;
  int failures = 0;

  // reference model
  int m_mode, m_run, m_since, m_snooze;
  bit m_seco, m_en, m_pulse, m_pend, m_lvl;
  bit bh[$];

  alarma_ctrl #(
    .DATA_W(8), .UMBRAL_SECO(80), .UMBRAL_HUMEDO(100), .N_CONSEC(NC),
    .T_ALARMA(TA), .T_SILENCIO(TS), .DEB_CYC(DB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .muestra_valid  (muestra_valid),
    .muestra        (muestra),
    .boton_silencio (boton_silencio),
    .alarma_en      (alarma_en),
    .alarma_reinicio(alarma_reinicio),
    .seco           (seco),
    .estado         (estado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_REPOSO; m_run = 0; m_since = 0; m_snooze = 0;
    m_seco = 0; m_en = 0; m_pulse = 0; m_pend = 0; m_lvl = 0;
    bh = {};
    for (int i = 0; i < DB + 2; i++) bh.push_back(1'b0);
  endtask

  task automatic enter_alarm();
    m_mode = M_ALARMA; m_since = 0; m_pulse = 1;
  endtask

  // One clock edge of the behaviour as seen from the pins.
  task automatic model_step(input bit r, input bit v, input int s, input bit b);
    bit press, differ, dry, wet;
    if (r) begin
      model_reset();
      return;
    end
    press = m_pend;
    // button reaches the debouncer two clocks late; accept after DB disagreeing samples
    bh.push_front(b);
    void'(bh.pop_back());
    differ = 1;
    for (int i = 2; i < DB + 2; i++) if (bh[i] == m_lvl) differ = 0;
    if (differ) begin
      m_lvl  = !m_lvl;
      m_pend = m_lvl;
    end else begin
      m_pend = 0;
    end
    dry = v && (s < 80);
    wet = v && (s >= 100);
    m_pulse = 0;
    case (m_mode)
      M_REPOSO: if (dry) begin
        m_run = 1;
        if (m_run == NC) enter_alarm(); else m_mode = M_CONTEO;
      end
      M_CONTEO: if (dry) begin
        m_run++;
        if (m_run == NC) enter_alarm();
      end else if (v) begin
        m_mode = M_REPOSO; m_run = 0;
      end
      M_ALARMA: begin
        m_since++;
        if (wet) begin
          m_mode = M_REPOSO; m_run = 0;
        end else if (press) begin
          m_mode = M_SILENCIO; m_snooze = 0;
        end else if (m_since % TA == 0) begin
          m_pulse = 1;
        end
      end
      default: begin
        m_snooze++;
        if (wet) begin
          m_mode = M_REPOSO; m_run = 0;
        end else if (m_snooze == TS) begin
          if (m_seco) enter_alarm();
          else begin
            m_mode = M_REPOSO; m_run = 0;
          end
        end
      end
    endcase
    if (dry) m_seco = 1;
    else if (wet) m_seco = 0;
    m_en = (m_mode == M_ALARMA);
  endtask

  task automatic ciclo(input bit r, input bit v, input int s, input bit b);
    rst = r; muestra_valid = v; muestra = 8'(s); boton_silencio = b;
    @(posedge clk);
    model_step(r, v, s, b);
    #1;
    chk("estado", 32'(estado), 32'(m_mode));
    chk("alarma_en", 32'(alarma_en), 32'(m_en));
    chk("reinicio", 32'(alarma_reinicio), 32'(m_pulse));
    chk("seco", 32'(seco), 32'(m_seco));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) ciclo(0, 0, 0, 0);
  endtask

  initial begin
    int npulse, nsil, guard, brun;
    bit bval;
    logic [1:0] prev;
    model_reset();
    rst = 1; muestra_valid = 0; muestra = '0; boton_silencio = 0;

    ciclo(1, 0, 0, 0);
    ciclo(1, 1, 10, 1);
    chk("reset_estado", 32'(estado), 0);
    chk("reset_en", 32'(alarma_en), 0);
    idle(2);

    // 1: three dry samples raise the alarm
    ciclo(0, 1, 70, 0); idle(1);
    ciclo(0, 1, 70, 0); idle(1);
    ciclo(0, 1, 70, 0);
    chk("s1_en", 32'(alarma_en), 1);
    chk("s1_reinicio", 32'(alarma_reinicio), 1);
    chk("s1_seco", 32'(seco), 1);
    idle(1);
    chk("s1_single_pulse", 32'(alarma_reinicio), 0);
    ciclo(0, 1, 120, 0); idle(1);

    // 2: a non-dry sample restarts the count
    ciclo(0, 1, 70, 0); ciclo(0, 1, 85, 0); ciclo(0, 1, 70, 0); ciclo(0, 1, 70, 0);
    chk("s2_no_alarm", 32'(alarma_en), 0);
    ciclo(0, 1, 70, 0);
    chk("s2_alarm", 32'(alarma_en), 1);

    // 3: melody restarts every TA clocks while held
    npulse = 0;
    for (int i = 1; i <= 250; i++) begin
      ciclo(0, 0, 0, 0);
      if (alarma_reinicio) begin
        npulse++;
        chk("s3_offset", i, npulse * TA);
      end
    end
    chk("s3_npulse", npulse, 2);
    chk("s3_en", 32'(alarma_en), 1);

    // 4: hysteresis band keeps the alarm, wet sample clears it
    ciclo(0, 1, 90, 0);
    chk("s4_estado", 32'(estado), 2);
    chk("s4_seco", 32'(seco), 1);
    ciclo(0, 1, 100, 0);
    chk("s4_en_off", 32'(alarma_en), 0);
    chk("s4_estado_reposo", 32'(estado), 0);
    chk("s4_seco_off", 32'(seco), 0);

    // 5: bouncy press snoozes once, alarm returns with a restart pulse
    ciclo(0, 1, 70, 0); ciclo(0, 1, 70, 0); ciclo(0, 1, 70, 0);
    nsil = 0; npulse = 0; prev = estado;
    for (int i = 0; i < 80; i++) begin
      ciclo(0, 0, 0, (i == 0 || (i >= 2 && i < 9)) ? 1'b1 : 1'b0);
      if (estado == 2'd3 && prev != 2'd3) nsil++;
      if (alarma_reinicio) npulse++;
      prev = estado;
    end
    chk("s5_one_snooze", nsil, 1);
    chk("s5_return_pulse", npulse, 1);
    chk("s5_back_alarm", 32'(estado), 2);

    // 6a: reset in the middle of an alarm
    ciclo(1, 0, 0, 0);
    chk("s6a_estado", 32'(estado), 0);
    chk("s6a_en", 32'(alarma_en), 0);
    chk("s6a_reinicio", 32'(alarma_reinicio), 0);
    idle(3);

    // 6b: wet sample on the same clock as snooze expiry
    ciclo(0, 1, 70, 0); ciclo(0, 1, 70, 0); ciclo(0, 1, 70, 0);
    guard = 0;
    while (!(m_mode == M_SILENCIO && m_snooze == TS - 1) && guard < 200) begin
      ciclo(0, 0, 0, guard < 8);
      guard++;
    end
    chk("s6b_reached_expiry", 32'(guard < 200), 1);
    ciclo(0, 1, 110, 0);
    chk("s6b_estado", 32'(estado), 0);
    chk("s6b_en", 32'(alarma_en), 0);
    chk("s6b_reinicio", 32'(alarma_reinicio), 0);

    // random samples, button activity and occasional reset
    brun = 0; bval = 0;
    for (int i = 0; i < 3000; i++) begin
      if (brun == 0) begin
        bval = 1'($urandom_range(0, 1));
        brun = $urandom_range(1, 8);
      end
      brun--;
      ciclo($urandom_range(0, 499) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(50, 130), bval);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarma_ctrl.md
Name: alarma_ctrl

Overview:
- Decides when the plant alarm sounds. Sits directly upstream of the melody/buzzer generator.
- Consumes soil-moisture samples from the ADC front end and a raw snooze push-button.
- Produces the generator's enable and a one-cycle restart pulse, so each alarm episode starts the melody from its first note.
- Applies hysteresis, a consecutive-sample filter, periodic melody re-trigger and a timed snooze.

Parameters:
DATA_W, 8, sample width
UMBRAL_SECO, 80, sample < this is "dry"
UMBRAL_HUMEDO, 100, sample >= this is "wet" (must be > UMBRAL_SECO)
N_CONSEC, 4, consecutive dry samples needed to raise alarm (>=1)
T_ALARMA, 1_090_000_000, clocks per melody period (restart interval)
T_SILENCIO, 500_000_000, snooze length in clocks
DEB_CYC, 1_000_000, clocks button must be stable to be accepted

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
muestra_valid  in  1  one-cycle strobe, muestra valid
muestra  in  DATA_W  moisture sample, unsigned, larger = wetter
boton_silencio  in  1  raw asynchronous snooze button, active-high
alarma_en  out  1  high = generator may sound
alarma_reinicio  out  1  one-cycle pulse: generator restarts melody
seco  out  1  hysteresis dry flag
estado  out  2  current FSM state (debug)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state REPOSO, alarma_en=0, alarma_reinicio=0, seco=0, consecutive counter=0, timer=0, debouncer stable state=0.
- Reset mid-operation behaves the same; there is no restart pulse on reset.
- Dry test is strict: muestra < UMBRAL_SECO. Wet test: muestra >= UMBRAL_HUMEDO. Comparisons are unsigned, DATA_W wide.
- seco flag:
  - set the cycle after a valid dry sample;
  - cleared the cycle after a valid wet sample;
  - otherwise held (hysteresis band).
- Button path:
  - 2-flop synchronizer, then sub-module antirrebote;
  - debounced level changes only after DEB_CYC consecutive equal synchronized samples;
  - "press" = one-cycle pulse on the debounced rising edge;
  - release is ignored.
- FSM states: REPOSO=0, CONTEO=1, ALARMA=2, SILENCIO=3. All outputs are registered.
  - REPOSO: valid dry sample -> counter=1. If N_CONSEC==1 go to ALARMA, else go to CONTEO. Other samples are ignored.
  - CONTEO:
    - valid dry sample -> counter+1; when the count reaches N_CONSEC -> ALARMA;
    - valid non-dry sample (>= UMBRAL_SECO) -> REPOSO, counter=0;
    - no valid -> hold.
  - ALARMA:
    - alarma_en=1;
    - on entry, timer=0 and alarma_reinicio pulses in the same cycle alarma_en first rises;
    - timer increments each clock; at timer==T_ALARMA-1, pulse alarma_reinicio and timer=0 (melody repeats);
    - valid wet sample -> REPOSO;
    - press -> SILENCIO, timer=0.
  - SILENCIO:
    - alarma_en=0; timer increments;
    - valid wet sample -> REPOSO;
    - press -> ignored;
    - at timer==T_SILENCIO-1: if seco=1 -> ALARMA (entry pulse again), else -> REPOSO.
- Priority in the same cycle: rst > wet sample > press > timer expiry.
  - Wet sample and expiry together -> REPOSO, no pulse.
  - Press and ALARMA expiry together -> SILENCIO, no pulse.
- Leaving ALARMA drops alarma_en on the next edge. Counter and timer are cleared on every entry to REPOSO.
- Widths: counter ceil(log2(N_CONSEC+1)); timer 32 bits, no wrap within the parameter ranges; debounce counter 20 bits.

Decomposition:
- Shared package alarma_pkg:
  - state encodings REPOSO/CONTEO/ALARMA/SILENCIO;
  - estado width;
  - default threshold constants, shared with the display block.
- One sub-module: antirrebote (parameter DEB_CYC). Inputs clk, rst, synchronized button. Outputs debounced level and press pulse.
- Synchronizer and FSM live in alarma_ctrl.

Test Plan:
Use N_CONSEC=3, T_ALARMA=100, T_SILENCIO=50, DEB_CYC=4, thresholds 80/100 for all scenarios.
1. Samples 70,70,70 -> alarma_en=1 one cycle after the third strobe; alarma_reinicio pulses once in that cycle; seco=1.
2. Samples 70,85,70,70 -> no alarm, because 85 resets the count; after a further 70 (three consecutive dry) the alarm rises.
3. Alarm held with no samples for 250 clocks -> alarma_reinicio pulses exactly at offsets 0, 100 and 200 from entry; alarma_en stays 1.
4. In ALARMA, sample 90 -> stays ALARMA, seco=1. Then sample 100 -> alarma_en=0 next cycle, state REPOSO, seco=0.
5. Button bounce 1,0,1 (1 clk each), then held 6 clks -> exactly one press pulse. Alarm goes to SILENCIO; after 50 clks with seco=1 it returns to ALARMA with a restart pulse.
6. rst asserted mid-ALARMA, and separately a wet sample coincident with SILENCIO expiry -> in both cases REPOSO, alarma_en=0, no restart pulse.
